pc_unit_ras: RTL and testbench
==============================

PC_UNIT_RAS -- requirements
Module: pc_unit_ras

Interface
REQ-001 Parameter ADDR_W, default 32, PC and target address width.
REQ-002 Parameter RESET_VECTOR, default 0, PC value after reset.
REQ-003 Parameter EXC_VECTOR, default 32'h80000180 truncated to ADDR_W, exception handler address.
REQ-004 Parameter RAS_DEPTH, default 4, return-address-stack entries; SHALL be a power of two, at least 2.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 PC_write_enable  in  1  1 = PC advances, 0 = stall (hazard unit).
REQ-008 PC_source  in  3  next-PC select: 000 PC+4, 001 branch, 010 jump, 011 jump-register, 100 exception, 101-111 treated as 000.
REQ-009 branch_target_address, jump_target_address, jr_target_address  in  ADDR_W each  candidate targets.
REQ-010 ras_push  in  1  link event (jal/jalr taken); pushes pc_plus_4 onto RAS.
REQ-011 ras_pop  in  1  return event (jr $ra); pops RAS top.
REQ-012 ras_flush  in  1  empties RAS.
REQ-013 pc_out  out  ADDR_W  current PC; pc_plus_4  out  ADDR_W  pc_out+4, modulo 2^ADDR_W.
REQ-014 ras_top  out  ADDR_W  predicted return address (top entry; 0 when empty).
REQ-015 ras_empty, ras_full  out  1 each  RAS occupancy flags.
REQ-016 target_misaligned  out  1  registered pulse; selected target had nonzero bits [1:0].
REQ-017 ras_overflow, ras_underflow  out  1 each  registered one-cycle event pulses.

Function
REQ-018 next_pc SHALL be chosen combinationally per PC_source from pc_plus_4, branch, jump, jr target, or EXC_VECTOR.
REQ-019 Bits [1:0] of next_pc SHALL be forced to 00; target_misaligned SHALL assert the cycle after a load whose selected target had nonzero [1:0] (PC+4 and exception never flag).
REQ-020 When PC_write_enable=1, pc_out SHALL load next_pc at the clock edge (latency 1).
REQ-021 When PC_write_enable=0 and PC_source!=100, pc_out SHALL hold; exception (100) SHALL load EXC_VECTOR regardless of PC_write_enable.
REQ-022 Exception load SHALL also empty the RAS in the same edge.
REQ-023 ras_push/ras_pop SHALL take effect only in cycles where PC_write_enable=1 (stall freezes RAS); ras_flush SHALL act regardless.
REQ-024 Push, not full: write pc_plus_4 at top+1, count+1.
REQ-025 Push, full: overwrite oldest entry (circular wrap), count stays RAS_DEPTH, ras_overflow pulses 1 cycle.
REQ-026 Pop, not empty: count-1, ras_top becomes next-older entry.
REQ-027 Pop, empty: no state change, ras_underflow pulses 1 cycle.
REQ-028 Push and pop same cycle, not empty: top entry replaced by pc_plus_4, count unchanged, no pulses.
REQ-029 Push and pop same cycle, empty: behaves as push only, no underflow.
REQ-030 ras_flush (or exception) SHALL have priority over push/pop in the same cycle; count becomes 0, no pulses.
REQ-031 Stack pointer arithmetic SHALL be modulo RAS_DEPTH; entry contents need not be cleared on flush.
REQ-032 ras_top, ras_empty, ras_full SHALL be derived from registered state only (valid in the cycle after the update).

Reset
REQ-033 On reset=1 at a rising edge: pc_out=RESET_VECTOR, RAS count=0, ras_empty=1, ras_full=0, all pulse outputs 0, ras_top=0.
REQ-034 Reset SHALL override PC_write_enable, PC_source, push, pop and flush in the same cycle, including mid-stall or mid-push.
REQ-035 Between reset deassertion and first edge, outputs SHALL remain at reset values.

Verification
REQ-036 Reset, then 3 cycles PC_source=000, enable=1 -> pc_out 0,4,8,C.
REQ-037 pc_out=0x10, branch target 0x40, enable=0 -> pc_out holds 0x10; enable=1 -> 0x40; target 0x43 -> pc_out 0x40, target_misaligned pulse 1 cycle.
REQ-038 PC_source=100 with enable=0 at pc_out=0x20 and RAS count 2 -> pc_out=0x80000180, ras_empty=1.
REQ-039 RAS_DEPTH=4: pushes at pc_out 0x0,0x4,0x8,0xC,0x10 -> ras_full=1, ras_overflow pulse on 5th, ras_top=0x14; four pops -> tops 0x10,0xC,0x8 then empty; 5th pop -> ras_underflow pulse, state unchanged.
REQ-040 Count 2, top 0x8, push+pop at pc_out 0x30 -> ras_top=0x34, count 2; push+pop when empty -> count 1, no pulse.
REQ-041 Push asserted with reset=1, or with ras_flush=1 -> RAS empty afterwards, no overflow pulse.

Source files
------------

// File: rtl/pc_unit_ras.sv
// Program counter with next-PC selection and a small circular return-address stack.
// The RAS overwrites its oldest entry on overflow, so deep call chains degrade gracefully.
module pc_unit_ras #(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter logic [ADDR_W-1:0] EXC_VECTOR   = ADDR_W'(32'h8000_0180),
    parameter int                RAS_DEPTH    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              PC_write_enable,
    input  logic [2:0]        PC_source,
    input  logic [ADDR_W-1:0] branch_target_address,
    input  logic [ADDR_W-1:0] jump_target_address,
    input  logic [ADDR_W-1:0] jr_target_address,
    input  logic              ras_push,
    input  logic              ras_pop,
    input  logic              ras_flush,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] pc_plus_4,
    output logic [ADDR_W-1:0] ras_top,
    output logic              ras_empty,
    output logic              ras_full,
    output logic              target_misaligned,
    output logic              ras_overflow,
    output logic              ras_underflow
);
    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [ADDR_W-1:0] next_raw, next_pc;
    logic              is_target, is_exc, load_pc, mis_next;

    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr_reg, ptr_next, wr_addr;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic              wr_en, ovf_next, udf_next;
    logic              push_en, pop_en, clear;
    logic              mis_reg, ovf_reg, udf_reg;

    assign pc_plus_4 = pc_reg + ADDR_W'(4);
    assign pc_out    = pc_reg;
    assign is_exc    = (PC_source == 3'b100);
    assign load_pc   = PC_write_enable | is_exc;

    always_comb begin
        next_raw  = pc_plus_4;
        is_target = 1'b0;
        case (PC_source)
            3'b001: begin next_raw = branch_target_address; is_target = 1'b1; end
            3'b010: begin next_raw = jump_target_address;   is_target = 1'b1; end
            3'b011: begin next_raw = jr_target_address;     is_target = 1'b1; end
            3'b100: next_raw = EXC_VECTOR;
            default: next_raw = pc_plus_4;
        endcase
        next_pc  = {next_raw[ADDR_W-1:2], 2'b00};
        pc_next  = load_pc ? next_pc : pc_reg;
        // Only a real load of a computed target can report misalignment.
        mis_next = PC_write_enable & is_target & (|next_raw[1:0]);
    end

    assign ras_empty = (count_reg == '0);
    assign ras_full  = (count_reg == CNT_W'(RAS_DEPTH));
    assign ras_top   = ras_empty ? '0 : ras_mem[ptr_reg];

    assign clear   = ras_flush | is_exc;
    assign push_en = ras_push & PC_write_enable;
    assign pop_en  = ras_pop & PC_write_enable;

    always_comb begin
        ptr_next   = ptr_reg;
        count_next = count_reg;
        wr_en      = 1'b0;
        wr_addr    = ptr_reg;
        ovf_next   = 1'b0;
        udf_next   = 1'b0;
        if (clear) begin
            count_next = '0;
        end else if (push_en && pop_en && !ras_empty) begin
            // Return immediately followed by a call: replace the top in place.
            wr_en = 1'b1;
        end else if (push_en) begin
            wr_en    = 1'b1;
            wr_addr  = ptr_reg + PTR_W'(1);
            ptr_next = ptr_reg + PTR_W'(1);
            if (ras_full) ovf_next   = 1'b1;
            else          count_next = count_reg + CNT_W'(1);
        end else if (pop_en) begin
            if (ras_empty) begin
                udf_next = 1'b1;
            end else begin
                ptr_next   = ptr_reg - PTR_W'(1);
                count_next = count_reg - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg    <= RESET_VECTOR;
            ptr_reg   <= '0;
            count_reg <= '0;
            mis_reg   <= 1'b0;
            ovf_reg   <= 1'b0;
            udf_reg   <= 1'b0;
        end else begin
            pc_reg    <= pc_next;
            ptr_reg   <= ptr_next;
            count_reg <= count_next;
            mis_reg   <= mis_next;
            ovf_reg   <= ovf_next;
            udf_reg   <= udf_next;
        end
    end

    // Entry storage carries no reset; occupancy is tracked by count_reg alone.
    always_ff @(posedge clk) begin
        if (!reset && wr_en) ras_mem[wr_addr] <= pc_plus_4;
    end

    assign target_misaligned = mis_reg;
    assign ras_overflow      = ovf_reg;
    assign ras_underflow     = udf_reg;
endmodule

// File: tb/tb_pc_unit_ras.sv
// Self-checking bench for pc_unit_ras: vector table for PC selection plus RAS sequences.
// Expected values are queued when a vector is driven and checked one edge later.
module tb_pc_unit_ras;
    localparam int AW = 32;

    typedef struct {
        logic          rst;
        logic          we;
        logic [2:0]    src;
        logic [AW-1:0] br;
        logic [AW-1:0] jmp;
        logic [AW-1:0] jr;
        logic          push;
        logic          pop;
        logic          flush;
        logic [AW-1:0] e_pc;
        logic [AW-1:0] e_top;
        logic          e_empty;
        logic          e_full;
        logic          e_mis;
        logic          e_ovf;
        logic          e_udf;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          PC_write_enable = 1'b0;
    logic [2:0]    PC_source = 3'b000;
    logic [AW-1:0] branch_target_address = '0;
    logic [AW-1:0] jump_target_address = '0;
    logic [AW-1:0] jr_target_address = '0;
    logic          ras_push = 1'b0;
    logic          ras_pop = 1'b0;
    logic          ras_flush = 1'b0;
    logic [AW-1:0] pc_out, pc_plus_4, ras_top;
    logic          ras_empty, ras_full, target_misaligned, ras_overflow, ras_underflow;

    int total = 0;
    int bad = 0;
    vec_t exp_q[$];
    vec_t tbl[14];

    pc_unit_ras #(.ADDR_W(AW), .RESET_VECTOR(32'h0), .EXC_VECTOR(32'h8000_0180), .RAS_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .PC_write_enable(PC_write_enable), .PC_source(PC_source),
        .branch_target_address(branch_target_address), .jump_target_address(jump_target_address),
        .jr_target_address(jr_target_address), .ras_push(ras_push), .ras_pop(ras_pop),
        .ras_flush(ras_flush), .pc_out(pc_out), .pc_plus_4(pc_plus_4), .ras_top(ras_top),
        .ras_empty(ras_empty), .ras_full(ras_full), .target_misaligned(target_misaligned),
        .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst, input logic we, input logic [2:0] src,
                                input logic [AW-1:0] br, input logic [AW-1:0] jmp,
                                input logic [AW-1:0] jr, input logic push, input logic pop,
                                input logic flush, input logic [AW-1:0] e_pc,
                                input logic [AW-1:0] e_top, input logic e_empty,
                                input logic e_full, input logic e_mis, input logic e_ovf,
                                input logic e_udf);
        vec_t v;
        v.rst = rst; v.we = we; v.src = src; v.br = br; v.jmp = jmp; v.jr = jr;
        v.push = push; v.pop = pop; v.flush = flush;
        v.e_pc = e_pc; v.e_top = e_top; v.e_empty = e_empty; v.e_full = e_full;
        v.e_mis = e_mis; v.e_ovf = e_ovf; v.e_udf = e_udf;
        return v;
    endfunction

    task automatic step(input vec_t t, input string name);
        vec_t e;
        logic [AW*2+4:0] got, want;
        @(negedge clk);
        reset = t.rst; PC_write_enable = t.we; PC_source = t.src;
        branch_target_address = t.br; jump_target_address = t.jmp; jr_target_address = t.jr;
        ras_push = t.push; ras_pop = t.pop; ras_flush = t.flush;
        exp_q.push_back(t);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        got  = {pc_out, ras_top, ras_empty, ras_full, target_misaligned, ras_overflow, ras_underflow};
        want = {e.e_pc, e.e_top, e.e_empty, e.e_full, e.e_mis, e.e_ovf, e.e_udf};
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got pc=%h top=%h emp=%b full=%b mis=%b ovf=%b udf=%b, want pc=%h top=%h emp=%b full=%b mis=%b ovf=%b udf=%b",
                     name, pc_out, ras_top, ras_empty, ras_full, target_misaligned, ras_overflow,
                     ras_underflow, e.e_pc, e.e_top, e.e_empty, e.e_full, e.e_mis, e.e_ovf, e.e_udf);
        end else begin
            $display("ok   %s: pc=%h top=%h emp=%b full=%b", name, pc_out, ras_top, ras_empty, ras_full);
        end
    endtask

    // RAS sequences keep branch/jr targets fixed and use only aligned jumps.
    task automatic go(input logic rst, input logic we, input logic [2:0] src,
                      input logic [AW-1:0] jmp, input logic push, input logic pop,
                      input logic flush, input logic [AW-1:0] e_pc, input logic [AW-1:0] e_top,
                      input logic e_empty, input logic e_full, input logic e_ovf,
                      input logic e_udf, input string name);
        step(mk(rst, we, src, 32'h40, jmp, 32'h300, push, pop, flush,
                e_pc, e_top, e_empty, e_full, 1'b0, e_ovf, e_udf), name);
    endtask

    initial begin
        //           rst we src     br      jmp     jr      psh pop fl  e_pc    top emp full mis ovf udf
        tbl[0]  = mk(1, 1, 3'b010, 32'h40, 32'h100, 32'h300, 1, 0, 0, 32'h000, 0, 1, 0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 3'b000, 32'h40, 32'h200, 32'h300, 0, 0, 0, 32'h004, 0, 1, 0, 0, 0, 0);
        tbl[2]  = mk(0, 1, 3'b000, 32'h40, 32'h200, 32'h300, 0, 0, 0, 32'h008, 0, 1, 0, 0, 0, 0);
        tbl[3]  = mk(0, 1, 3'b000, 32'h40, 32'h200, 32'h300, 0, 0, 0, 32'h00C, 0, 1, 0, 0, 0, 0);
        tbl[4]  = mk(0, 1, 3'b000, 32'h40, 32'h200, 32'h300, 0, 0, 0, 32'h010, 0, 1, 0, 0, 0, 0);
        tbl[5]  = mk(0, 0, 3'b001, 32'h40, 32'h200, 32'h300, 0, 0, 0, 32'h010, 0, 1, 0, 0, 0, 0);
        tbl[6]  = mk(0, 1, 3'b001, 32'h40, 32'h200, 32'h300, 0, 0, 0, 32'h040, 0, 1, 0, 0, 0, 0);
        tbl[7]  = mk(0, 1, 3'b001, 32'h43, 32'h200, 32'h300, 0, 0, 0, 32'h040, 0, 1, 0, 1, 0, 0);
        tbl[8]  = mk(0, 1, 3'b000, 32'h43, 32'h200, 32'h300, 0, 0, 0, 32'h044, 0, 1, 0, 0, 0, 0);
        tbl[9]  = mk(0, 1, 3'b010, 32'h40, 32'h200, 32'h300, 0, 0, 0, 32'h200, 0, 1, 0, 0, 0, 0);
        tbl[10] = mk(0, 1, 3'b011, 32'h40, 32'h200, 32'h300, 0, 0, 0, 32'h300, 0, 1, 0, 0, 0, 0);
        tbl[11] = mk(0, 1, 3'b111, 32'h40, 32'h200, 32'h300, 0, 0, 0, 32'h304, 0, 1, 0, 0, 0, 0);
        tbl[12] = mk(0, 0, 3'b010, 32'h40, 32'h202, 32'h300, 0, 0, 0, 32'h304, 0, 1, 0, 0, 0, 0);
        tbl[13] = mk(0, 1, 3'b011, 32'h40, 32'h200, 32'h301, 0, 0, 0, 32'h300, 0, 1, 0, 1, 0, 0);

        for (int i = 0; i < 14; i++) step(tbl[i], $sformatf("vec%0d", i));

        // Fill past depth, then drain past empty.
        go(1, 0, 3'b000, 0, 0, 0, 0, 32'h00, 32'h00, 1, 0, 0, 0, "ras_reset");
        go(0, 1, 3'b000, 0, 1, 0, 0, 32'h04, 32'h04, 0, 0, 0, 0, "push1");
        go(0, 1, 3'b000, 0, 1, 0, 0, 32'h08, 32'h08, 0, 0, 0, 0, "push2");
        go(0, 1, 3'b000, 0, 1, 0, 0, 32'h0C, 32'h0C, 0, 0, 0, 0, "push3");
        go(0, 1, 3'b000, 0, 1, 0, 0, 32'h10, 32'h10, 0, 1, 0, 0, "push4_full");
        go(0, 1, 3'b000, 0, 1, 0, 0, 32'h14, 32'h14, 0, 1, 1, 0, "push5_overflow");
        go(0, 1, 3'b000, 0, 0, 1, 0, 32'h18, 32'h10, 0, 0, 0, 0, "pop1");
        go(0, 1, 3'b000, 0, 0, 1, 0, 32'h1C, 32'h0C, 0, 0, 0, 0, "pop2");
        go(0, 1, 3'b000, 0, 0, 1, 0, 32'h20, 32'h08, 0, 0, 0, 0, "pop3");
        go(0, 1, 3'b000, 0, 0, 1, 0, 32'h24, 32'h00, 1, 0, 0, 0, "pop4_empty");
        go(0, 1, 3'b000, 0, 0, 1, 0, 32'h28, 32'h00, 1, 0, 0, 1, "pop5_underflow");
        go(0, 1, 3'b000, 0, 0, 0, 0, 32'h2C, 32'h00, 1, 0, 0, 0, "underflow_clear");
        go(0, 0, 3'b000, 0, 1, 0, 0, 32'h2C, 32'h00, 1, 0, 0, 0, "push_stalled");

        // Simultaneous push and pop, non-empty and empty.
        go(1, 0, 3'b000, 0, 0, 0, 0, 32'h00, 32'h00, 1, 0, 0, 0, "pp_reset");
        go(0, 1, 3'b000, 0, 1, 0, 0, 32'h04, 32'h04, 0, 0, 0, 0, "pp_push1");
        go(0, 1, 3'b000, 0, 1, 0, 0, 32'h08, 32'h08, 0, 0, 0, 0, "pp_push2");
        go(0, 1, 3'b010, 32'h30, 0, 0, 0, 32'h30, 32'h08, 0, 0, 0, 0, "pp_jump");
        go(0, 1, 3'b000, 0, 1, 1, 0, 32'h34, 32'h34, 0, 0, 0, 0, "pp_replace");
        go(0, 1, 3'b000, 0, 0, 1, 0, 32'h38, 32'h04, 0, 0, 0, 0, "pp_pop_older");
        go(0, 1, 3'b000, 0, 0, 1, 0, 32'h3C, 32'h00, 1, 0, 0, 0, "pp_pop_empty");
        go(0, 1, 3'b000, 0, 1, 1, 0, 32'h40, 32'h40, 0, 0, 0, 0, "pp_empty_push");
        go(0, 1, 3'b000, 0, 0, 1, 0, 32'h44, 32'h00, 1, 0, 0, 0, "pp_count_one");

        // Exception during stall, flush with push, reset with push.
        go(0, 1, 3'b010, 32'h18, 0, 0, 0, 32'h18, 32'h00, 1, 0, 0, 0, "exc_jump");
        go(0, 1, 3'b000, 0, 1, 0, 0, 32'h1C, 32'h1C, 0, 0, 0, 0, "exc_push1");
        go(0, 1, 3'b000, 0, 1, 0, 0, 32'h20, 32'h20, 0, 0, 0, 0, "exc_push2");
        go(0, 0, 3'b100, 0, 1, 0, 0, 32'h8000_0180, 32'h0, 1, 0, 0, 0, "exception_stalled");
        go(0, 1, 3'b000, 0, 1, 0, 0, 32'h8000_0184, 32'h8000_0184, 0, 0, 0, 0, "post_exc_push");
        go(0, 1, 3'b000, 0, 1, 0, 1, 32'h8000_0188, 32'h0, 1, 0, 0, 0, "flush_with_push");
        go(0, 1, 3'b000, 0, 1, 0, 0, 32'h8000_018C, 32'h8000_018C, 0, 0, 0, 0, "push_after_flush");
        go(1, 1, 3'b010, 32'h500, 1, 0, 0, 32'h0, 32'h0, 1, 0, 0, 0, "reset_with_push");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
